// File: rtl/irq_pkg.sv
// Shared definitions for the 8-source interrupt controller: register map,
// spurious vector code and handshake FSM encoding.
package irq_pkg;

   localparam logic [2:0] REG_PEND = 3'd0;
   localparam logic [2:0] REG_MASK = 3'd1;
   localparam logic [2:0] REG_EDGE = 3'd2;
   localparam logic [2:0] REG_ISR  = 3'd3;
   localparam logic [2:0] REG_VEC  = 3'd4;
   localparam logic [2:0] REG_EOI  = 3'd5;
   localparam logic [2:0] REG_RAW  = 3'd6;
   localparam logic [2:0] REG_CTRL = 3'd7;

   localparam logic [7:0] SPURIOUS_VEC = 8'hFF;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ASSERT = 1'b1
   } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// 8-bit find-first-set: idx is the lowest set bit (bit 0 = highest priority),
// valid is high when any bit is set.
module irq_prio_enc (
   input  logic [7:0] bits,
   output logic       valid,
   output logic [2:0] idx
);

   always_comb begin
      valid = |bits;
      idx   = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (bits[i]) idx = i[2:0];
      end
   end

endmodule

// File: rtl/irq_controller.sv
// 8-source priority interrupt controller with a CPU-bus register file and a
// vectored acknowledge. Define IRQ_NESTING_EN to let a higher source preempt.
module irq_controller
   import irq_pkg::*;
#(
   parameter logic [7:0] VECTOR_BASE = 8'h20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] addr,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   input  logic       read,
   input  logic       write,
   input  logic       cs,
   input  logic [7:0] irq_in,
   output logic       cpu_irq,
   input  logic       cpu_ack,
   output logic [7:0] vector,
   output irq_state_e state_dbg
);

   // Handshake: the CPU pulses cpu_ack for one cycle while cpu_irq is high;
   // the vector is captured on that edge and cpu_irq is low the next cycle.
   irq_state_e state_q, state_d;

   logic [7:0] mask_q, edge_q, pend_q, isr_q, irq_in_d, vector_q;
   logic       gen_q, cpu_irq_q, cpu_irq_d;

   logic [7:0] pend_view, req, win_onehot, eoi_clr, w1c, edge_set, ack_clr;
   logic       req_valid, isr_valid, eligible, ack_take, wr, rd, eoi;
   logic [2:0] win_idx, isr_idx;

   assign wr = cs & write;
   assign rd = cs & read;

   // Edge sources read from the latched bit, level sources track irq_in live.
   assign pend_view = (pend_q & edge_q) | (irq_in & ~edge_q);
   assign req       = pend_view & ~mask_q & {8{gen_q}};

   irq_prio_enc u_req_enc (.bits(req),   .valid(req_valid), .idx(win_idx));
   irq_prio_enc u_isr_enc (.bits(isr_q), .valid(isr_valid), .idx(isr_idx));

`ifdef IRQ_NESTING_EN
   assign eligible = req_valid && (!isr_valid || (win_idx < isr_idx));
`else
   assign eligible = req_valid && !isr_valid;
`endif

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (eligible) state_d = ST_ASSERT;
         ST_ASSERT: if (cpu_ack || !eligible) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ack_take   = (state_q == ST_ASSERT) && cpu_ack && eligible;
      win_onehot = 8'b1 << win_idx;
      cpu_irq_d  = (state_d == ST_ASSERT);
   end

   assign edge_set = irq_in & ~irq_in_d & edge_q;
   assign w1c      = (wr && addr == REG_PEND) ? (data_in & edge_q) : 8'h00;
   assign ack_clr  = ack_take ? win_onehot : 8'h00;
   assign eoi      = wr && (addr == REG_EOI);
   // EOI retires the highest-priority in-service source as seen before this edge.
   assign eoi_clr  = (eoi && isr_valid) ? (8'b1 << isr_idx) : 8'h00;

   always_ff @(posedge clk) begin
      if (rst) begin
         mask_q    <= 8'hFF;
         edge_q    <= 8'h00;
         gen_q     <= 1'b0;
         pend_q    <= 8'h00;
         isr_q     <= 8'h00;
         irq_in_d  <= 8'h00;
         vector_q  <= SPURIOUS_VEC;
         cpu_irq_q <= 1'b0;
      end else begin
         irq_in_d  <= irq_in;
         cpu_irq_q <= cpu_irq_d;
         pend_q    <= ((pend_q & ~w1c & ~ack_clr) | edge_set) & edge_q;
         isr_q     <= (isr_q & ~eoi_clr) | ack_clr;
         if (cpu_ack) vector_q <= ack_take ? {VECTOR_BASE[7:3], win_idx} : SPURIOUS_VEC;
         if (wr && addr == REG_MASK) mask_q <= data_in;
         if (wr && addr == REG_EDGE) edge_q <= data_in;
         if (wr && addr == REG_CTRL) gen_q  <= data_in[0];
      end
   end

   always_comb begin
      data_out = 8'h00;
      if (rd) begin
         case (addr)
            REG_PEND: data_out = pend_view;
            REG_MASK: data_out = mask_q;
            REG_EDGE: data_out = edge_q;
            REG_ISR:  data_out = isr_q;
            REG_VEC:  data_out = vector_q;
            REG_EOI:  data_out = 8'h00;
            REG_RAW:  data_out = irq_in;
            REG_CTRL: data_out = {7'b0, gen_q};
            default:  data_out = 8'h00;
         endcase
      end
   end

   assign cpu_irq   = cpu_irq_q;
   assign vector    = vector_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: scoreboard queue of expected values,
// immediate assertions at each comparison, one summary line at the end.
module tb_irq_controller;
   import irq_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] addr;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       read, write, cs;
   logic [7:0] irq_in;
   logic       cpu_irq;
   logic       cpu_ack;
   logic [7:0] vector;
   irq_state_e state_dbg;

   logic [7:0] exp_q[$];
   int checks   = 0;
   int failures = 0;

   irq_controller #(.VECTOR_BASE(8'h20)) dut (
      .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .data_out(data_out),
      .read(read), .write(write), .cs(cs), .irq_in(irq_in), .cpu_irq(cpu_irq),
      .cpu_ack(cpu_ack), .vector(vector), .state_dbg(state_dbg)
   );

   // Clock / watchdog
   always #50 clk = ~clk;

   initial begin
      #(100 * 20000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Driver tasks
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
      cs = 1'b1; write = 1'b1; addr = a; data_in = d;
      step();
      cs = 1'b0; write = 1'b0; data_in = 8'h00;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
      cs = 1'b1; read = 1'b1; addr = a;
      #1;
      d = data_out;
      cs = 1'b0; read = 1'b0;
   endtask

   // Scoreboard
   task automatic expect_val(input logic [7:0] v);
      exp_q.push_back(v);
   endtask

   task automatic check(input string tag, input logic [7:0] obs);
      logic [7:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $error("FAIL %s: observed %h with empty expected queue", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
         end
      end
   endtask

   task automatic check_reg(input string tag, input logic [2:0] a, input logic [7:0] e);
      logic [7:0] d;
      expect_val(e);
      bus_read(a, d);
      check(tag, d);
   endtask

   task automatic check_sig(input string tag, input logic [7:0] obs, input logic [7:0] e);
      expect_val(e);
      check(tag, obs);
   endtask

   task automatic wait_irq(input string tag, input int max_cycles);
      int n = 0;
      expect_val(8'h01);
      while (cpu_irq !== 1'b1 && n < max_cycles) begin
         step();
         n++;
      end
      check(tag, {7'b0, cpu_irq});
   endtask

   task automatic do_ack(input string tag, input logic [7:0] exp_vec);
      expect_val(exp_vec);
      cpu_ack = 1'b1;
      step();
      cpu_ack = 1'b0;
      check(tag, vector);
   endtask

   // Directed sequence
   initial begin
      logic seen;
      int   n;
      rst = 1'b1; addr = 3'd0; data_in = 8'h00; read = 1'b0; write = 1'b0;
      cs = 1'b0; irq_in = 8'h00; cpu_ack = 1'b0;
      step(2);
      rst = 1'b0;

      check_sig("rst_cpu_irq", {7'b0, cpu_irq}, 8'h00);
      check_sig("rst_vector", vector, 8'hFF);
      check_sig("rst_state", 8'(state_dbg), 8'(ST_IDLE));
      check_reg("rst_mask", REG_MASK, 8'hFF);
      check_reg("rst_edge", REG_EDGE, 8'h00);
      check_reg("rst_pend", REG_PEND, 8'h00);
      check_reg("rst_isr", REG_ISR, 8'h00);
      check_reg("rst_ctrl", REG_CTRL, 8'h00);

      // 1: single edge pulse on source 0, two-cycle latency
      bus_write(REG_CTRL, 8'h01);
      bus_write(REG_MASK, 8'hFE);
      bus_write(REG_EDGE, 8'h01);
      irq_in = 8'h01;
      check_reg("t1_raw", REG_RAW, 8'h01);
      step();
      irq_in = 8'h00;
      check_sig("t1_irq_early", {7'b0, cpu_irq}, 8'h00);
      check_reg("t1_pend_set", REG_PEND, 8'h01);
      step();
      check_sig("t1_latency", {7'b0, cpu_irq}, 8'h01);
      do_ack("t1_vector", 8'h20);
      check_sig("t1_irq_drop", {7'b0, cpu_irq}, 8'h00);
      check_reg("t1_isr", REG_ISR, 8'h01);
      check_reg("t1_pend", REG_PEND, 8'h00);
      check_reg("t1_vec_reg", REG_VEC, 8'h20);
      bus_write(REG_EOI, 8'h5A);
      check_reg("t1_isr_eoi", REG_ISR, 8'h00);

      // 2: two simultaneous edges are served in priority order
      bus_write(REG_MASK, 8'h00);
      bus_write(REG_EDGE, 8'hFF);
      irq_in = 8'h28;
      wait_irq("t2_irq_a", 10);
      do_ack("t2_vector_a", 8'h23);
      check_reg("t2_isr_a", REG_ISR, 8'h08);
      step(2);
      check_sig("t2_blocked", {7'b0, cpu_irq}, 8'h00);
      bus_write(REG_EOI, 8'h00);
      wait_irq("t2_irq_b", 10);
      do_ack("t2_vector_b", 8'h25);
      bus_write(REG_EOI, 8'h00);
      check_reg("t2_isr_end", REG_ISR, 8'h00);
      irq_in = 8'h00;

      // 3: level source re-requests after EOI, PEND follows the pin
      bus_write(REG_EDGE, 8'hEF);
      irq_in = 8'h10;
      wait_irq("t3_irq", 10);
      do_ack("t3_vector", 8'h24);
      check_reg("t3_isr", REG_ISR, 8'h10);
      bus_write(REG_PEND, 8'h10);
      check_reg("t3_pend_level", REG_PEND, 8'h10);
      bus_write(REG_EOI, 8'h00);
      wait_irq("t3_reassert", 10);
      irq_in = 8'h00;
      check_reg("t3_pend_drop", REG_PEND, 8'h00);
      step();
      check_sig("t3_withdrawn", {7'b0, cpu_irq}, 8'h00);

      // 4: higher source arrives while a lower one is in service
      bus_write(REG_EDGE, 8'hFF);
      irq_in = 8'h40;
      wait_irq("t4_irq_6", 10);
      do_ack("t4_vector_6", 8'h26);
      check_reg("t4_isr_6", REG_ISR, 8'h40);
      irq_in = 8'h42;
`ifdef IRQ_NESTING_EN
      wait_irq("t4_preempt", 10);
      do_ack("t4_vector_1", 8'h21);
      check_reg("t4_isr_nested", REG_ISR, 8'h42);
      bus_write(REG_EOI, 8'h00);
      check_reg("t4_isr_eoi1", REG_ISR, 8'h40);
      bus_write(REG_EOI, 8'h00);
`else
      seen = 1'b0;
      n = $urandom_range(3, 8);
      repeat (n) begin
         step();
         seen = seen | cpu_irq;
      end
      check_sig("t4_no_preempt", {7'b0, seen}, 8'h00);
      bus_write(REG_EOI, 8'h00);
      check_reg("t4_isr_eoi", REG_ISR, 8'h00);
      wait_irq("t4_irq_1", 10);
      do_ack("t4_vector_1", 8'h21);
      check_reg("t4_isr_1", REG_ISR, 8'h02);
      bus_write(REG_EOI, 8'h00);
`endif
      check_reg("t4_isr_end", REG_ISR, 8'h00);
      irq_in = 8'h00;

      // 5: masked pending edge, unmask, re-mask before ack
      bus_write(REG_MASK, 8'hFF);
      irq_in = 8'h04;
      step(3);
      irq_in = 8'h00;
      check_sig("t5_masked", {7'b0, cpu_irq}, 8'h00);
      check_reg("t5_pend", REG_PEND, 8'h04);
      bus_write(REG_MASK, 8'h00);
      wait_irq("t5_unmasked", 10);
      bus_write(REG_MASK, 8'hFF);
      check_sig("t5_prewrite_mask", {7'b0, cpu_irq}, 8'h01);
      step();
      check_sig("t5_remasked", {7'b0, cpu_irq}, 8'h00);
      do_ack("t5_spurious", 8'hFF);
      check_reg("t5_isr", REG_ISR, 8'h00);
      check_reg("t5_pend_kept", REG_PEND, 8'h04);
      bus_write(REG_PEND, 8'h04);
      check_reg("t5_pend_w1c", REG_PEND, 8'h00);

      // 6: set beats W1C; reset in the middle of a request
      irq_in = 8'h80;
      bus_write(REG_PEND, 8'h80);
      check_reg("t6_set_wins", REG_PEND, 8'h80);
      bus_write(REG_MASK, 8'h7E);
      wait_irq("t6_irq_7", 10);
      do_ack("t6_vector_7", 8'h27);
      bus_write(REG_EOI, 8'h00);
      irq_in = 8'h81;
      wait_irq("t6_irq_0", 10);
      check_sig("t6_state_assert", 8'(state_dbg), 8'(ST_ASSERT));
      rst = 1'b1;
      irq_in = 8'h00;
      step();
      check_sig("t6_rst_cpu_irq", {7'b0, cpu_irq}, 8'h00);
      check_sig("t6_rst_vector", vector, 8'hFF);
      check_sig("t6_rst_state", 8'(state_dbg), 8'(ST_IDLE));
      check_reg("t6_rst_isr", REG_ISR, 8'h00);
      check_reg("t6_rst_pend", REG_PEND, 8'h00);
      check_reg("t6_rst_mask", REG_MASK, 8'hFF);
      check_reg("t6_rst_ctrl", REG_CTRL, 8'h00);
      rst = 1'b0;
      step();

      // Final report
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL leftover_expected: observed %0d entries expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
